// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier, WORD_LENGTH x WORD_LENGTH -> 2*WORD_LENGTH.
// Optional `SIGNED_MULT_EN: two's-complement operands via magnitude multiply plus sign fix-up.
//
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// RUN   | one shift-add iteration per edge, WORD_LENGTH iterations
// DONE  | product valid, ready pulses for this single cycle
module shift_add_multiplier #(
   parameter int WORD_LENGTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WORD_LENGTH-1:0]     multiplicand,
   input  logic [WORD_LENGTH-1:0]     multiplier,
   output logic [2*WORD_LENGTH-1:0]   product,
   output logic                       ready,
   output logic                       busy
);

   localparam int PW    = 2 * WORD_LENGTH;
   localparam int CNT_W = $clog2(WORD_LENGTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state, state_next;
   logic [PW-1:0]          mcand_r;
   logic [WORD_LENGTH-1:0] mplr_r;
   logic [PW-1:0]          acc;
   logic [PW-1:0]          acc_next;
   logic [PW-1:0]          result;
   logic [CNT_W-1:0]       cnt;
   logic                   last_iter;
   logic [WORD_LENGTH-1:0] load_a;
   logic [WORD_LENGTH-1:0] load_b;

`ifdef SIGNED_MULT_EN
   logic neg_r;

   // Negating the most negative value wraps to itself, which read unsigned is 2^(W-1).
   assign load_a = multiplicand[WORD_LENGTH-1] ? (~multiplicand + WORD_LENGTH'(1)) : multiplicand;
   assign load_b = multiplier[WORD_LENGTH-1]   ? (~multiplier   + WORD_LENGTH'(1)) : multiplier;
   assign result = neg_r ? (~acc_next + PW'(1)) : acc_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         neg_r <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_r <= multiplicand[WORD_LENGTH-1] ^ multiplier[WORD_LENGTH-1];
      end
   end
`else
   assign load_a = multiplicand;
   assign load_b = multiplier;
   assign result = acc_next;
`endif

   assign acc_next  = acc + (mplr_r[0] ? mcand_r : '0);
   assign last_iter = (cnt == CNT_W'(WORD_LENGTH - 1));
   assign busy      = (state != IDLE);
   assign ready     = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_r <= '0;
         mplr_r  <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand_r <= {{WORD_LENGTH{1'b0}}, load_a};
                  mplr_r  <= load_b;
                  acc     <= '0;
                  cnt     <= '0;
               end
            end
            RUN: begin
               acc     <= acc_next;
               mcand_r <= mcand_r << 1;
               mplr_r  <= mplr_r >> 1;
               cnt     <= cnt + CNT_W'(1);
               if (last_iter) begin
                  product <= result;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: scoreboard of expected products,
// latency, reset priority, start-ignored-while-busy and back-to-back throughput.
module tb_shift_add_multiplier;

   localparam int WL = 16;
   localparam int PW = 2 * WL;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [WL-1:0] multiplicand = '0;
   logic [WL-1:0] multiplier = '0;
   logic [PW-1:0] product;
   logic          ready;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int ready_cnt = 0;
   logic [PW-1:0] sb_q[$];
   logic [PW-1:0] last_exp = '0;

   shift_add_multiplier #(.WORD_LENGTH(WL)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .ready        (ready),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ready === 1'b1) ready_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [PW-1:0] model(input logic [WL-1:0] a, input logic [WL-1:0] b);
`ifdef SIGNED_MULT_EN
      logic signed [PW-1:0] sa, sb, sp;
      sa = $signed({{WL{a[WL-1]}}, a});
      sb = $signed({{WL{b[WL-1]}}, b});
      sp = sa * sb;
      return sp;
`else
      return {{WL{1'b0}}, a} * {{WL{1'b0}}, b};
`endif
   endfunction

   // Drives one start pulse; returns just after the accepting edge.
   task automatic accept(input logic [WL-1:0] a, input logic [WL-1:0] b, input bit push);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      if (push) sb_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_accept: got %b expected 1", busy);
      end
   endtask

   // Waits (bounded) for ready, checks latency and scoreboard head, then the hold cycle.
   task automatic wait_result(input string name);
      int lat = 0;
      logic [PW-1:0] exp_p;
      while (ready !== 1'b1 && lat < WL + 4) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (ready !== 1'b1 || lat != WL) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles (ready=%b) expected %0d", name, lat, ready, WL);
      end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s_scoreboard: queue empty, expected one pending result", name);
         return;
      end
      exp_p = sb_q.pop_front();
      last_exp = exp_p;
      if (product !== exp_p) begin
         errors++;
         $display("FAIL %s_product: got %h expected %h", name, product, exp_p);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
         errors++;
         $display("FAIL %s_hold: got ready=%b busy=%b product=%h expected 0 0 %h",
                  name, ready, busy, product, exp_p);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      multiplicand = 16'h0003;
      multiplier   = 16'h0005;
      repeat (2) begin
         @(posedge clk);
         #1;
         checks++;
         if (product !== '0 || ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got product=%h ready=%b busy=%b expected 0 0 0",
                     product, ready, busy);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (product !== '0 || ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got product=%h ready=%b busy=%b expected 0 0 0",
                     product, ready, busy);
         end
      end
   endtask

   task automatic test_basic();
      accept(16'h0003, 16'h0005, 1'b1);
      wait_result("mul_3x5");
      checks++;
      if (last_exp !== 32'h0000000F) begin
         errors++;
         $display("FAIL mul_3x5_model: model gave %h expected 0000000f", last_exp);
      end
   endtask

   task automatic test_corners();
      accept(16'hFFFF, 16'hFFFF, 1'b1);
      wait_result("mul_ffff");
      accept(16'h0000, 16'h1234, 1'b1);
      wait_result("mul_zero");
      checks++;
      if (product !== 32'h0) begin
         errors++;
         $display("FAIL mul_zero_const: got %h expected 00000000", product);
      end
      accept(16'h1234, 16'h0001, 1'b1);
      wait_result("mul_by_one");
      accept(16'hABCD, 16'h8001, 1'b1);
      wait_result("mul_mixed");
   endtask

   task automatic test_back_to_back();
      int rc0;
      accept(16'h0007, 16'h0009, 1'b1);
      rc0 = ready_cnt;
      for (int e = 1; e <= 18; e++) begin
         @(negedge clk);
         multiplicand = 16'h0002;
         multiplier   = 16'h0002;
         start = (e == 3 || e == 17 || e == 18);
         if (e == 18) sb_q.push_back(model(16'h0002, 16'h0002));
         @(posedge clk);
         #1;
         if (e == 16) begin
            checks++;
            if (ready !== 1'b1 || product !== model(16'h0007, 16'h0009)) begin
               errors++;
               $display("FAIL b2b_first: got ready=%b product=%h expected 1 %h",
                        ready, product, model(16'h0007, 16'h0009));
            end
            void'(sb_q.pop_front());
         end
         if (e == 17) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL b2b_done_start_ignored: got busy=%b expected 0", busy);
            end
         end
         if (e == 18) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_idle_accept: got busy=%b expected 1", busy);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (ready_cnt - rc0 != 1) begin
         errors++;
         $display("FAIL b2b_ready_count: got %0d pulses expected 1", ready_cnt - rc0);
      end
      wait_result("b2b_second");
   endtask

   task automatic test_reset_mid_run();
      int rc0;
      accept(16'h00FF, 16'h0100, 1'b0);
      rc0 = ready_cnt;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (product !== '0 || busy !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got product=%h busy=%b ready=%b expected 0 0 0",
                  product, busy, ready);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (WL + 4) @(posedge clk);
      #1;
      checks++;
      if (ready_cnt != rc0 || busy !== 1'b0 || product !== '0) begin
         errors++;
         $display("FAIL midrun_no_ready: got pulses=%0d busy=%b product=%h expected 0 0 0",
                  ready_cnt - rc0, busy, product);
      end
      accept(16'h0004, 16'h0004, 1'b1);
      wait_result("after_reset_4x4");
   endtask

   task automatic test_signed_vectors();
      accept(16'hFFFD, 16'h0005, 1'b1);
      wait_result("sgn_m3x5");
      accept(16'h8000, 16'h8000, 1'b1);
      wait_result("sgn_min_min");
      accept(16'h8000, 16'h0001, 1'b1);
      wait_result("sgn_min_one");
`ifdef SIGNED_MULT_EN
      checks++;
      if (product !== 32'hFFFF8000) begin
         errors++;
         $display("FAIL sgn_min_one_const: got %h expected ffff8000", product);
      end
`endif
   endtask

   task automatic test_random();
      logic [WL-1:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = WL'($urandom);
         b = WL'($urandom);
         accept(a, b, 1'b1);
         wait_result("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_back_to_back();
      test_reset_mid_run();
      test_signed_vectors();
      test_random();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential radix-2 shift-and-add multiplier, WORD_LENGTH x WORD_LENGTH to 2*WORD_LENGTH bits.
- Consumes the shift-left-by-one stage. Each iteration, the multiplicand register is replaced by itself << 1. The same function is available as the 32-bit one-bit left shifter in the P2 datapath.
- Provides the start/ready control wrapper around that shift path.
- Intended as the multiply unit that the P2 top level drives.

Parameters:
WORD_LENGTH, 16, operand width in bits; product width is 2*WORD_LENGTH.

Ports:
clk            input   1                clock, all state updates on rising edge
reset          input   1                synchronous, active-high reset
start          input   1                request; sampled only in IDLE
multiplicand   input   WORD_LENGTH      operand A, sampled on accepted start
multiplier     input   WORD_LENGTH      operand B, sampled on accepted start
product        output  2*WORD_LENGTH    registered result; held until next result or reset
ready          output  1                one-cycle pulse: product valid and just updated
busy           output  1                high while state != IDLE

Behaviour:
- Reset (sampled at rising edge of clk with reset=1):
  - Next state IDLE.
  - product=0, ready=0, busy=0.
  - Internal accumulator, shift registers and iteration counter cleared.
  - Reset has priority over every other input, including a start in the same cycle.
- States: IDLE, RUN, DONE. busy = (state != IDLE); ready = (state == DONE).
- IDLE:
  - start=1 at edge k: load mcand_r (2*WORD_LENGTH bits) = zero-extended multiplicand.
  - Load mplr_r = multiplier, acc=0, cnt=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - acc_next = acc + (mplr_r[0] ? mcand_r : 0).
  - mcand_r <= mcand_r << 1 (bits shifted out of the MSB are discarded).
  - mplr_r <= mplr_r >> 1; cnt <= cnt + 1.
  - acc is 2*WORD_LENGTH wide and cannot overflow.
- RUN exit:
  - On the edge where cnt == WORD_LENGTH-1, product <= acc_next and state goes to DONE.
  - Exactly WORD_LENGTH RUN iterations are performed, at edges k+1 .. k+WORD_LENGTH.
- DONE: ready=1 for exactly one cycle, then the next edge goes to IDLE.
- Latency:
  - Start accepted at edge k.
  - ready high in the cycle following edge k+WORD_LENGTH.
  - A new start is accepted no earlier than edge k+WORD_LENGTH+2, giving a throughput of one result per WORD_LENGTH+2 cycles with start held high.
- start while RUN or DONE: ignored; operand inputs are ignored outside the accepting edge.
- No early termination: zero operands still take the full latency.
- cnt width is $clog2(WORD_LENGTH); WORD_LENGTH must be >= 2.
- Reset mid-RUN: the operation is abandoned and product is cleared to 0; no ready pulse.

Optional Feature:
SIGNED_MULT_EN
- Defined: operands are two's complement.
  - On accepted start, each operand is loaded as its magnitude (|x|, with the most negative value giving 2^(WORD_LENGTH-1) unsigned).
  - neg_r = multiplicand[MSB] ^ multiplier[MSB] is captured.
  - On the RUN-exit edge, product <= neg_r ? -acc_next : acc_next, in 2*WORD_LENGTH-bit two's complement.
  - Latency is unchanged.
- Undefined: operands are unsigned; the neg_r register and negation logic are absent.

Test Plan:
1. Assert reset 2 cycles with start=1 -> product=0, ready=0, busy=0 throughout and after release; no operation started.
2. WORD_LENGTH=16, start pulse with 3 x 5 at edge k -> busy high from edge k; ready pulse after edge k+16; product=0x0000000F, held after ready drops.
3. 0xFFFF x 0xFFFF -> product=0xFFFE0001. Then 0x0000 x 0x1234 -> product=0x00000000 with the same 16-cycle latency.
4. Start 7 x 9, then assert start with 2 x 2 at edges k+3 and k+17 (DONE) -> single result 0x0000003F; the second request is accepted only when start is seen in IDLE.
5. Start 0x00FF x 0x0100, assert reset at edge k+8 -> no ready pulse, product=0, busy=0. A subsequent 4 x 4 gives 0x00000010 with normal latency.
6. SIGNED_MULT_EN defined:
   - 0xFFFD x 0x0005 -> 0xFFFFFFF1.
   - 0x8000 x 0x8000 -> 0x40000000.
   - 0x8000 x 0x0001 -> 0xFFFF8000.
